// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm bank: channel state
// encoding, hour/minute field type and wrap-aware minute addition.
package alarm_pkg;

  localparam int TIME_W = 7;

  typedef logic [TIME_W-1:0] time_field_t;

  localparam time_field_t MAX_HOUR   = 7'd23;
  localparam time_field_t MAX_MINUTE = 7'd59;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZED
  } alarm_state_e;

  typedef struct packed {
    time_field_t hour;
    time_field_t minute;
  } hm_t;

  // Minutes argument is at most 59, so a single carry into the hour is enough.
  function automatic hm_t add_minutes(input time_field_t hour,
                                      input time_field_t minute,
                                      input time_field_t minutes);
    hm_t             result;
    logic [TIME_W:0] sum;
    sum           = {1'b0, minute} + {1'b0, minutes};
    result.hour   = hour;
    result.minute = sum[TIME_W-1:0];
    if (sum > {1'b0, MAX_MINUTE}) begin
      result.minute = TIME_W'(sum - (TIME_W+1)'(60));
      result.hour   = (hour == MAX_HOUR) ? '0 : hour + TIME_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, enable bit, and the ring/snooze state
// machine with its snooze target, snooze counter and ring timeout timer.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  time_field_t cur_hour,
  input  time_field_t cur_minute,
  input  time_field_t cur_second,
  input  logic        hour_inc,
  input  logic        minute_inc,
  input  logic        toggle,
  input  logic        snooze,
  input  logic        stop,
  output time_field_t alarm_hour,
  output time_field_t alarm_minute,
  output logic        enable,
  output logic        ringing
);

  localparam int CNT_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam int TMR_W = (RING_TIMEOUT < 2) ? 1 : $clog2(RING_TIMEOUT);

  localparam logic [CNT_W-1:0] SNOOZE_LIMIT = CNT_W'(MAX_SNOOZE);
  localparam logic [TMR_W-1:0] TIMER_LAST   = TMR_W'(RING_TIMEOUT - 1);
  localparam time_field_t      SNOOZE_STEP  = TIME_W'(SNOOZE_MIN);

  alarm_state_e     state, state_next;
  logic [CNT_W-1:0] snooze_count, count_next;
  logic [TMR_W-1:0] ring_timer, timer_next;
  hm_t              target, target_next;
  hm_t              snooze_time;
  logic             minute_start, alarm_hit, target_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hour   <= '0;
      alarm_minute <= '0;
      enable       <= 1'b0;
    end else begin
      if (hour_inc)
        alarm_hour <= (alarm_hour == MAX_HOUR) ? '0 : alarm_hour + TIME_W'(1);
      if (minute_inc)
        alarm_minute <= (alarm_minute == MAX_MINUTE) ? '0 : alarm_minute + TIME_W'(1);
      if (toggle)
        enable <= ~enable;
    end
  end

  assign minute_start = sec_tick && (cur_second == '0);
  assign alarm_hit    = minute_start && (cur_hour == alarm_hour) && (cur_minute == alarm_minute);
  assign target_hit   = minute_start && (cur_hour == target.hour) && (cur_minute == target.minute);
  assign snooze_time  = add_minutes(cur_hour, cur_minute, SNOOZE_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      snooze_count <= '0;
      ring_timer   <= '0;
      target       <= '0;
    end else begin
      state        <= state_next;
      snooze_count <= count_next;
      ring_timer   <= timer_next;
      target       <= target_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = snooze_count;
    timer_next  = ring_timer;
    target_next = target;
    // A toggle while enabled is a disable; a toggle while disabled leaves IDLE as is.
    if (!enable || toggle) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (alarm_hit) begin
            state_next = RINGING;
            timer_next = '0;
            count_next = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_next = ARMED;
          end else if (snooze) begin
            if (snooze_count < SNOOZE_LIMIT) begin
              state_next  = SNOOZED;
              target_next = snooze_time;
              count_next  = snooze_count + CNT_W'(1);
            end else begin
              state_next = ARMED;
            end
          end else if (sec_tick) begin
            if (ring_timer == TIMER_LAST) state_next = ARMED;
            else                          timer_next = ring_timer + TMR_W'(1);
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_next = ARMED;
          end else if (target_hit) begin
            state_next = RINGING;
            timer_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ringing = (state == RINGING);

endmodule

// File: rtl/alarm_bank.sv
// Bank of independently editable alarm channels: button release detection,
// per-channel edit routing, selected-channel readback and ring priority encoding.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int SEL_W        = 2,
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic [TIME_W-1:0]     cur_hour,
  input  logic [TIME_W-1:0]     cur_minute,
  input  logic [TIME_W-1:0]     cur_second,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  add_hour_signal,
  input  logic                  add_minute_signal,
  input  logic                  toggle_signal,
  input  logic                  snooze_signal,
  input  logic                  stop_signal,
  output logic [TIME_W-1:0]     sel_hour,
  output logic [TIME_W-1:0]     sel_minute,
  output logic [NUM_ALARMS-1:0] alarm_enable,
  output logic                  ringing,
  output logic [SEL_W-1:0]      ring_channel
);

  logic [4:0] btn_now, btn_prev, btn_release;
  logic       hour_rel, minute_rel, toggle_rel, snooze_rel, stop_rel;

  time_field_t           ch_hour   [NUM_ALARMS];
  time_field_t           ch_minute [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] ch_ringing;

  assign btn_now = {stop_signal, snooze_signal, toggle_signal, add_minute_signal, add_hour_signal};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_prev <= '0;
    else        btn_prev <= btn_now;
  end

  // Buttons act on release, so the action fires when the held level drops.
  assign btn_release = btn_prev & ~btn_now;
  assign hour_rel    = btn_release[0];
  assign minute_rel  = btn_release[1];
  assign toggle_rel  = btn_release[2];
  assign snooze_rel  = btn_release[3];
  assign stop_rel    = btn_release[4];

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_channel
    logic selected;
    assign selected = (sel == SEL_W'(i));

    alarm_channel #(
      .SNOOZE_MIN  (SNOOZE_MIN),
      .MAX_SNOOZE  (MAX_SNOOZE),
      .RING_TIMEOUT(RING_TIMEOUT)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .sec_tick    (sec_tick),
      .cur_hour    (cur_hour),
      .cur_minute  (cur_minute),
      .cur_second  (cur_second),
      .hour_inc    (hour_rel && selected),
      .minute_inc  (minute_rel && selected),
      .toggle      (toggle_rel && selected),
      .snooze      (snooze_rel),
      .stop        (stop_rel),
      .alarm_hour  (ch_hour[i]),
      .alarm_minute(ch_minute[i]),
      .enable      (alarm_enable[i]),
      .ringing     (ch_ringing[i])
    );
  end

  // Out-of-range selects match no channel and therefore read back as zero.
  always_comb begin
    sel_hour   = '0;
    sel_minute = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hour   = ch_hour[i];
        sel_minute = ch_minute[i];
      end
    end
  end

  always_comb begin
    ring_channel = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ch_ringing[i]) ring_channel = SEL_W'(i);
    end
  end

  assign ringing = |ch_ringing;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed plus randomized bench for alarm_bank, checked against a time-of-day
// reference model that tracks each channel as ringing/snoozed flags and minute targets.
module tb_alarm_bank;

  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int TMO  = 60;

  localparam logic [4:0] B_HOUR   = 5'b00001;
  localparam logic [4:0] B_MIN    = 5'b00010;
  localparam logic [4:0] B_TOGGLE = 5'b00100;
  localparam logic [4:0] B_SNOOZE = 5'b01000;
  localparam logic [4:0] B_STOP   = 5'b10000;

  logic         clk;
  logic         reset;
  logic         sec_tick;
  logic [6:0]   cur_hour, cur_minute, cur_second;
  logic [1:0]   sel;
  logic         add_hour_signal, add_minute_signal, toggle_signal, snooze_signal, stop_signal;
  logic [6:0]   sel_hour, sel_minute;
  logic [N-1:0] alarm_enable;
  logic         ringing;
  logic [1:0]   ring_channel;

  int checks   = 0;
  int failures = 0;

  int m_hour [N];
  int m_min  [N];
  bit m_en   [N];
  bit m_ring [N];
  bit m_snz  [N];
  int m_count[N];
  int m_secs [N];
  int m_tgt  [N];
  int now_s;

  alarm_bank #(
    .NUM_ALARMS  (N),
    .SEL_W       (2),
    .SNOOZE_MIN  (SNZ),
    .MAX_SNOOZE  (MAXS),
    .RING_TIMEOUT(TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sec_tick         (sec_tick),
    .cur_hour         (cur_hour),
    .cur_minute       (cur_minute),
    .cur_second       (cur_second),
    .sel              (sel),
    .add_hour_signal  (add_hour_signal),
    .add_minute_signal(add_minute_signal),
    .toggle_signal    (toggle_signal),
    .snooze_signal    (snooze_signal),
    .stop_signal      (stop_signal),
    .sel_hour         (sel_hour),
    .sel_minute       (sel_minute),
    .alarm_enable     (alarm_enable),
    .ringing          (ringing),
    .ring_channel     (ring_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_hour[i] = 0; m_min[i] = 0; m_en[i] = 0; m_ring[i] = 0;
      m_snz[i] = 0; m_count[i] = 0; m_secs[i] = 0; m_tgt[i] = 0;
    end
  endtask

  task automatic driveTime();
    cur_hour   = 7'(now_s / 3600);
    cur_minute = 7'((now_s / 60) % 60);
    cur_second = 7'(now_s % 60);
  endtask

  // Place the clock one second before the given minute-of-day, without a tick.
  task automatic jumpToMinute(input int minute_of_day);
    now_s = (minute_of_day * 60 - 1 + 86400) % 86400;
    driveTime();
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int          exp_ch;
    bit          exp_ring;
    logic [31:0] exp_en;
    int          k;
    exp_ch = 0; exp_ring = 0; exp_en = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_ring[i]) begin exp_ring = 1; exp_ch = i; end
      exp_en[i] = m_en[i];
    end
    k = int'(sel);
    checkValue({tag, ".ringing"}, 32'(ringing), 32'(exp_ring));
    checkValue({tag, ".ring_channel"}, 32'(ring_channel), exp_ch);
    checkValue({tag, ".alarm_enable"}, 32'(alarm_enable), exp_en);
    checkValue({tag, ".sel_hour"}, 32'(sel_hour), (k < N) ? m_hour[k] : 0);
    checkValue({tag, ".sel_minute"}, 32'(sel_minute), (k < N) ? m_min[k] : 0);
  endtask

  // Press and release the buttons in mask, then one settling cycle; model follows.
  task automatic applyStimulus(input logic [4:0] mask);
    int k;
    add_hour_signal   = mask[0];
    add_minute_signal = mask[1];
    toggle_signal     = mask[2];
    snooze_signal     = mask[3];
    stop_signal       = mask[4];
    @(negedge clk);
    {stop_signal, snooze_signal, toggle_signal, add_minute_signal, add_hour_signal} = 5'b0;
    @(negedge clk);
    @(negedge clk);
    k = int'(sel);
    if (k < N) begin
      if (mask[0]) m_hour[k] = (m_hour[k] + 1) % 24;
      if (mask[1]) m_min[k]  = (m_min[k] + 1) % 60;
      if (mask[2]) begin
        m_en[k] = !m_en[k];
        if (!m_en[k]) begin m_ring[k] = 0; m_snz[k] = 0; end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && !(mask[2] && i == k)) begin
        if (mask[4]) begin
          m_ring[i] = 0; m_snz[i] = 0;
        end else if (mask[3] && m_ring[i]) begin
          m_ring[i] = 0;
          if (m_count[i] < MAXS) begin
            m_snz[i]   = 1;
            m_tgt[i]   = (now_s / 60 + SNZ) % 1440;
            m_count[i] = m_count[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic secondTick();
    int mod;
    now_s = (now_s + 1) % 86400;
    driveTime();
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    mod = now_s / 60;
    for (int i = 0; i < N; i++) begin
      if (m_en[i]) begin
        if (m_ring[i]) begin
          m_secs[i] = m_secs[i] + 1;
          if (m_secs[i] >= TMO) m_ring[i] = 0;
        end else if (m_snz[i]) begin
          if (now_s % 60 == 0 && mod == m_tgt[i]) begin
            m_ring[i] = 1; m_snz[i] = 0; m_secs[i] = 0;
          end
        end else if (now_s % 60 == 0 && mod == m_hour[i] * 60 + m_min[i]) begin
          m_ring[i] = 1; m_secs[i] = 0; m_count[i] = 0;
        end
      end
    end
  endtask

  task automatic setChannel(input int ch, input int hours, input int minutes);
    sel = 2'(ch);
    repeat (hours) applyStimulus(B_HOUR);
    repeat (minutes) applyStimulus(B_MIN);
  endtask

  initial begin
    logic [4:0] mask;
    int         c;
    reset = 1'b0;
    sec_tick = 1'b0;
    sel = '0;
    {stop_signal, snooze_signal, toggle_signal, add_minute_signal, add_hour_signal} = 5'b0;
    now_s = 0;
    driveTime();
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_hold");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_release");

    $display("[TB] edit wrap on channel 1");
    setChannel(1, 24, 0);
    checkValue("edit.hour_wrap", 32'(sel_hour), 0);
    setChannel(1, 0, 61);
    checkValue("edit.minute_wrap", 32'(sel_minute), 1);
    applyStimulus(B_HOUR | B_MIN);
    checkValue("edit.both_hour", 32'(sel_hour), 1);
    checkValue("edit.both_minute", 32'(sel_minute), 2);
    checkOutput("edit");

    $display("[TB] trigger channel 2, disabled channel 3 silent");
    setChannel(2, 7, 30);
    applyStimulus(B_TOGGLE);
    setChannel(3, 7, 30);
    jumpToMinute(7 * 60 + 30);
    secondTick();
    checkValue("trigger.ringing", 32'(ringing), 1);
    checkValue("trigger.ring_channel", 32'(ring_channel), 2);
    checkOutput("trigger");
    applyStimulus(B_STOP);
    checkOutput("trigger_stop");

    $display("[TB] snooze across midnight on channel 0");
    setChannel(0, 23, 58);
    applyStimulus(B_TOGGLE);
    jumpToMinute(23 * 60 + 58);
    secondTick();
    checkOutput("snooze.ring0");
    for (int s = 1; s <= MAXS; s++) begin
      applyStimulus(B_SNOOZE);
      checkValue("snooze.silent", 32'(ringing), 0);
      jumpToMinute((23 * 60 + 58 + s * SNZ) % 1440);
      secondTick();
      checkValue("snooze.rering", 32'(ringing), 1);
      checkOutput("snooze.step");
    end
    applyStimulus(B_SNOOZE);
    checkValue("snooze.limit_stop", 32'(ringing), 0);
    jumpToMinute(18);
    secondTick();
    checkValue("snooze.no_more", 32'(ringing), 0);
    checkOutput("snooze.done");

    $display("[TB] multi-ring, stop, then timeout");
    setChannel(0, 7, 2);
    setChannel(1, 5, 58);
    applyStimulus(B_TOGGLE);
    jumpToMinute(6 * 60);
    secondTick();
    checkValue("multi.ring_channel", 32'(ring_channel), 0);
    checkOutput("multi");
    applyStimulus(B_STOP);
    checkOutput("multi.stop");
    jumpToMinute(6 * 60);
    secondTick();
    repeat (TMO - 1) secondTick();
    checkValue("timeout.before", 32'(ringing), 1);
    checkOutput("timeout.before");
    secondTick();
    checkValue("timeout.after", 32'(ringing), 0);
    checkOutput("timeout.after");

    $display("[TB] disable channel 1 while snoozed");
    jumpToMinute(6 * 60);
    secondTick();
    applyStimulus(B_SNOOZE);
    sel = 2'd1;
    applyStimulus(B_TOGGLE);
    checkValue("disable.enable1", 32'(alarm_enable[1]), 0);
    jumpToMinute(6 * 60 + SNZ);
    secondTick();
    checkOutput("disable.target");
    sel = 2'd0;
    applyStimulus(B_TOGGLE);
    checkValue("disable.ch1_silent", 32'(ringing), 0);
    checkOutput("disable.done");

    $display("[TB] asynchronous reset while ringing");
    jumpToMinute(7 * 60 + 30);
    secondTick();
    checkOutput("areset.ring");
    #2 reset = 1'b0;
    #1;
    checkValue("areset.ringing", 32'(ringing), 0);
    checkValue("areset.ring_channel", 32'(ring_channel), 0);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    sel = 2'd2;
    checkValue("areset.enable", 32'(alarm_enable), 0);
    checkValue("areset.sel_hour", 32'(sel_hour), 0);
    checkOutput("areset.after");

    $display("[TB] randomized phase");
    for (int step = 0; step < 200; step++) begin
      if ($urandom_range(0, 9) < 4) begin
        if ($urandom_range(0, 1) == 1) begin
          c = int'($urandom_range(0, N - 1));
          jumpToMinute(m_snz[c] ? m_tgt[c] : m_hour[c] * 60 + m_min[c]);
        end
        secondTick();
      end else begin
        sel  = 2'($urandom_range(0, N - 1));
        mask = 5'($urandom_range(1, 31));
        if ($urandom_range(0, 3) != 0) mask[2] = 1'b0;
        applyStimulus(mask);
      end
      checkOutput("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
Multi-channel successor to the single alarm register: NUM_ALARMS independently editable, enable-able alarms compared against the running clock time. Each channel has its own ring/snooze state machine with snooze limit and auto-stop timeout. Sits between the timekeeping counter and the display/buzzer logic; buttons come from the board debouncers.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..16)
SEL_W, 2, width of channel select = clog2(NUM_ALARMS), min 1
SNOOZE_MIN, 5, minutes added per snooze (1..59)
MAX_SNOOZE, 3, snoozes allowed per ring episode; further snooze acts as stop
RING_TIMEOUT, 60, seconds a channel rings before auto-stop

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sec_tick  in  1  one-cycle pulse at each new second of the time counter
cur_hour  in  7  current hour 0..23
cur_minute  in  7  current minute 0..59
cur_second  in  7  current second 0..59
sel  in  SEL_W  channel targeted by edit/toggle buttons
add_hour_signal  in  1  debounced button; action on release (1->0)
add_minute_signal  in  1  debounced button; action on release
toggle_signal  in  1  debounced button; release flips enable of channel sel
snooze_signal  in  1  debounced button; release snoozes all ringing channels
stop_signal  in  1  debounced button; release stops all ringing/snoozed channels
sel_hour  out  7  stored alarm hour of channel sel (combinational mux)
sel_minute  out  7  stored alarm minute of channel sel
alarm_enable  out  NUM_ALARMS  per-channel enable
ringing  out  1  OR of all channels in RINGING
ring_channel  out  SEL_W  lowest-index ringing channel; 0 when none

Behaviour:
- Reset (reset=0, async): all hours/minutes 0, enables 0, all FSMs IDLE, snooze counts 0, timers 0, edge-detect history 0. So ringing=0, ring_channel=0.
- Button edge: registered previous value; edge = prev & ~cur; one-cycle action, registered results visible next cycle.
- Edit: hour edge -> hour of channel sel +1, 23 wraps to 0; minute edge -> +1, 59 wraps to 0. Hour and minute edges in the same cycle both apply. Edits allowed in any state; they change the stored alarm, never an active snooze target.
- Toggle: flips enable[sel]. Disabling forces that channel to IDLE (stops ringing) next cycle.
- Per-channel FSM: IDLE (disabled), ARMED, RINGING, SNOOZED.
  IDLE -> ARMED when enabled.
  ARMED -> RINGING on sec_tick with cur_second==0 and cur_hour/cur_minute equal to stored alarm; timer cleared, snooze count cleared.
  RINGING -> SNOOZED on snooze edge if count<MAX_SNOOZE: target = cur_time + SNOOZE_MIN minutes (minute wrap carries into hour, 23 wraps to 0), count+1.
  RINGING -> ARMED on snooze edge with count==MAX_SNOOZE, on stop edge, or when timer reaches RING_TIMEOUT sec_ticks.
  SNOOZED -> RINGING on sec_tick, cur_second==0, time == snooze target; timer cleared, count kept.
  SNOOZED -> ARMED on stop edge.
- Priority in one cycle: reset > disable > stop > snooze > timeout > trigger. Trigger and edit same cycle: trigger compares pre-edit value.
- Channels are independent; several may ring at once; snooze/stop apply to every channel in the relevant state.
- sel out of range (>= NUM_ALARMS): edits/toggles ignored, sel_hour/sel_minute read 0.
- Time inputs assumed legal; no range checking.

Decomposition:
- Package alarm_pkg: state enum (IDLE, ARMED, RINGING, SNOOZED), constants MAX_HOUR=23, MAX_MINUTE=59, time width 7, function for add-minutes-with-wrap.
- Sub-module alarm_channel: one channel's stored time, FSM, snooze target, snooze counter and ring timer; top instantiates NUM_ALARMS via generate, holds edge detectors, select decode, priority encoder for ring_channel.

Test Plan:
- Reset mid-ring: ch0 RINGING, pull reset low asynchronously -> ringing=0 immediately, sel_hour=0, alarm_enable=0 after release.
- Edit wrap: sel=1, 24 hour releases from 0 -> sel_hour=0; 61 minute releases -> sel_minute=1; simultaneous hour+minute release -> both increment.
- Trigger: ch2 set 07:30 enabled, time reaches 07:30:00 with sec_tick -> ringing=1, ring_channel=2 next cycle; disabled ch3 at same time stays silent.
- Snooze wrap: ch0 rings at 23:58, snooze -> SNOOZED, target 00:03; at 00:03:00 rings again; after 3 snoozes the 4th snooze returns to ARMED, ringing=0.
- Timeout and multi-ring: ch0 and ch1 both at 06:00 -> ring_channel=0; stop -> both ARMED; retrigger next day, no buttons -> ringing drops after 60 sec_ticks.
- Disable while snoozed: ch1 SNOOZED, sel=1 toggle -> alarm_enable[1]=0, no ring at snooze target.
